// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer with level, almost-full, sticky overrun and character timeout
module uart_rx_fifo #(
  parameter int NCHAR          = 8,
  parameter int DEPTH          = 16,
  parameter int ALMOST_FULL    = 12,
  parameter int DROP_ERR       = 0,
  parameter int TIMEOUT_CYCLES = 19096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCHAR-1:0]           rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_frame_error,
  input  logic                       rx_parity_error,
  output logic [NCHAR-1:0]           m_data,
  output logic                       m_frame_error,
  output logic                       m_parity_error,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic                       flush,
  input  logic                       overrun_clr,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       overrun,
  output logic                       timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [NCHAR+1:0] mem [DEPTH];
  logic [NCHAR+1:0] head;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lvl_n;
  logic empty, full, pop, push_req, push, ovr_evt, act, expired;
  assign empty    = wp == rp;
  assign full     = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign head     = mem[rp[AW-1:0]];
  assign m_valid  = ~empty;
  assign m_data         = empty ? '0 : head[NCHAR-1:0];
  assign m_frame_error  = empty ? 1'b0 : head[NCHAR];
  assign m_parity_error = empty ? 1'b0 : head[NCHAR+1];
  assign pop      = ~empty & m_ready;
  assign push_req = rx_valid & ~((DROP_ERR != 0) & (rx_frame_error | rx_parity_error));
  // a full FIFO still accepts a character when the head leaves in the same cycle
  assign push     = push_req & (~full | pop) & ~flush;
  assign ovr_evt  = push_req & full & ~pop & ~flush;
  assign act      = push | pop | flush;
  assign expired  = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign lvl_n    = flush ? '0 : level + LW'(push) - LW'(pop);
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {rx_parity_error, rx_frame_error, rx_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      almost_full <= 1'b0;
      overrun     <= 1'b0;
      cnt         <= '0;
      timeout     <= 1'b0;
    end else begin
      wp          <= flush ? '0 : wp + PW'(push);
      rp          <= flush ? '0 : rp + PW'(pop);
      level       <= lvl_n;
      almost_full <= lvl_n >= LW'(ALMOST_FULL);
      overrun     <= ovr_evt | (overrun & ~overrun_clr);
      cnt         <= (act | empty) ? '0 : expired ? cnt : cnt + CW'(1);
      timeout     <= (act | empty) ? 1'b0 : (timeout | expired);
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed checks of uart_rx_fifo against a queue-based reference model
module tb_uart_rx_fifo;
  localparam int DEPTH = 16, AF = 12, T = 100;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0, rx_fe = 0, rx_pe = 0, m_ready = 0, flush = 0, overrun_clr = 0;
  logic rx_valid_d = 0, m_ready_d = 0;
  logic [7:0] m_data, m_data_d;
  logic m_fe, m_pe, m_valid, af, ovr_o, to;
  logic m_fe_d, m_pe_d, m_valid_d, af_d, ovr_d, to_d;
  logic [4:0] level, level_d;
  logic [9:0] q[$];
  bit ovr;
  int cyc_n, last_act, vecs, errs;
  wire [18:0] obs = {m_valid, m_pe, m_fe, m_data, level, af, ovr_o, to};

  uart_rx_fifo #(.NCHAR(8), .DEPTH(DEPTH), .ALMOST_FULL(AF), .DROP_ERR(0), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_error(rx_fe),
    .rx_parity_error(rx_pe), .m_data(m_data), .m_frame_error(m_fe), .m_parity_error(m_pe),
    .m_valid(m_valid), .m_ready(m_ready), .flush(flush), .overrun_clr(overrun_clr),
    .level(level), .almost_full(af), .overrun(ovr_o), .timeout(to));

  uart_rx_fifo #(.NCHAR(8), .DEPTH(DEPTH), .ALMOST_FULL(AF), .DROP_ERR(1), .TIMEOUT_CYCLES(T)) dut_drop (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_d), .rx_frame_error(rx_fe),
    .rx_parity_error(rx_pe), .m_data(m_data_d), .m_frame_error(m_fe_d), .m_parity_error(m_pe_d),
    .m_valid(m_valid_d), .m_ready(m_ready_d), .flush(flush), .overrun_clr(overrun_clr),
    .level(level_d), .almost_full(af_d), .overrun(ovr_d), .timeout(to_d));

  always #5 clk = ~clk;

  function automatic logic [18:0] expv();
    logic [9:0] h;
    logic t;
    h = q.size() > 0 ? q[0] : 10'd0;
    t = q.size() > 0 && (cyc_n - last_act >= T);
    return {q.size() > 0, h, 5'(q.size()), q.size() >= AF, ovr, t};
  endfunction

  task automatic cyc();
    int n;
    bit pop, act;
    n = q.size();
    pop = m_ready && n > 0;
    act = 0;
    if (rst) begin
      q.delete();
      ovr = 0;
    end else begin
      if (overrun_clr) ovr = 0;
      if (flush) begin
        q.delete();
        act = 1;
      end else begin
        if (pop) begin
          void'(q.pop_front());
          act = 1;
        end
        if (rx_valid) begin
          if (n < DEPTH || pop) begin
            q.push_back({rx_pe, rx_fe, rx_data});
            act = 1;
          end else ovr = 1;
        end
      end
    end
    @(posedge clk);
    cyc_n++;
    if (act) last_act = cyc_n;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    rx_data = d; rx_valid = 1;
    cyc();
    rx_valid = 0;
  endtask

  task automatic clear_all();
    flush = 1; overrun_clr = 1;
    cyc();
    flush = 0; overrun_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(); cyc();
    vecs++;
    if (obs !== 19'd0) begin
      $display("FAIL reset: got %h expected %h", obs, 19'd0); errs++;
    end
    rst = 0;
    cyc();
    vecs++;
    if (obs !== expv()) begin
      $display("FAIL reset_idle: got %h expected %h", obs, expv()); errs++;
    end
  endtask

  task automatic test_basic();
    push(8'hA5);
    vecs++;
    if (obs !== expv() || m_data !== 8'hA5 || level !== 5'd1) begin
      $display("FAIL basic_push: got %h expected %h", obs, expv()); errs++;
    end
    m_ready = 1;
    cyc();
    m_ready = 0;
    vecs++;
    if (obs !== expv() || m_valid !== 1'b0) begin
      $display("FAIL basic_pop: got %h expected %h", obs, expv()); errs++;
    end
  endtask

  task automatic test_fill_overrun();
    clear_all();
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      vecs++;
      if (obs !== expv() || af !== (i + 1 >= AF)) begin
        $display("FAIL fill_%0d: got %h expected %h", i, obs, expv()); errs++;
      end
    end
    push(8'h55);
    vecs++;
    if (obs !== expv() || ovr_o !== 1'b1 || level !== 5'd16) begin
      $display("FAIL overrun_set: got %h expected %h", obs, expv()); errs++;
    end
    m_ready = 1;
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (obs !== expv() || m_data !== 8'(i)) begin
        $display("FAIL drain_%0d: got %h expected %h", i, obs, expv()); errs++;
      end
      cyc();
    end
    m_ready = 0;
    vecs++;
    if (obs !== expv() || m_valid !== 1'b0) begin
      $display("FAIL drain_empty: got %h expected %h", obs, expv()); errs++;
    end
    overrun_clr = 1;
    cyc();
    overrun_clr = 0;
    vecs++;
    if (obs !== expv() || ovr_o !== 1'b0) begin
      $display("FAIL overrun_clr: got %h expected %h", obs, expv()); errs++;
    end
  endtask

  task automatic test_full_pop();
    clear_all();
    for (int i = 0; i < 16; i++) push(8'($urandom));
    rx_data = 8'hAA; rx_valid = 1; m_ready = 1;
    cyc();
    rx_valid = 0; m_ready = 0;
    vecs++;
    if (obs !== expv() || level !== 5'd16 || ovr_o !== 1'b0) begin
      $display("FAIL full_push_pop: got %h expected %h", obs, expv()); errs++;
    end
    m_ready = 1;
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (obs !== expv()) begin
        $display("FAIL full_drain_%0d: got %h expected %h", i, obs, expv()); errs++;
      end
      if (i == 15 && m_data !== 8'hAA) begin
        $display("FAIL full_last: got %h expected %h", m_data, 8'hAA); errs++;
      end
      cyc();
    end
    m_ready = 0;
  endtask

  task automatic test_drop_err();
    clear_all();
    rx_fe = 1; rx_valid_d = 1;
    push(8'h3C);
    rx_fe = 0; rx_valid_d = 0;
    vecs++;
    if (level_d !== 5'd0 || m_valid_d !== 1'b0) begin
      $display("FAIL drop_err: got level %h expected %h", level_d, 5'd0); errs++;
    end
    vecs++;
    if (obs !== expv() || m_fe !== 1'b1 || m_data !== 8'h3C) begin
      $display("FAIL keep_err: got %h expected %h", obs, expv()); errs++;
    end
    rx_valid_d = 1;
    push(8'h7E);
    rx_valid_d = 0;
    vecs++;
    if (level_d !== 5'd1 || m_data_d !== 8'h7E) begin
      $display("FAIL drop_good: got %h/%h expected %h/%h", level_d, m_data_d, 5'd1, 8'h7E); errs++;
    end
  endtask

  task automatic test_timeout();
    clear_all();
    push(8'h42);
    for (int k = 1; k <= T + 2; k++) begin
      cyc();
      vecs++;
      if (obs !== expv() || to !== (k >= T)) begin
        $display("FAIL timeout_%0d: got %h expected %h", k, obs, expv()); errs++;
      end
    end
    m_ready = 1;
    cyc();
    m_ready = 0;
    vecs++;
    if (obs !== expv() || to !== 1'b0) begin
      $display("FAIL timeout_pop: got %h expected %h", obs, expv()); errs++;
    end
  endtask

  task automatic test_flush_rst();
    clear_all();
    for (int i = 0; i < 17; i++) push(8'($urandom));
    flush = 1; rx_valid = 1; rx_data = 8'h99;
    cyc();
    flush = 0; rx_valid = 0;
    vecs++;
    if (obs !== expv() || level !== 5'd0 || m_valid !== 1'b0 || ovr_o !== 1'b1) begin
      $display("FAIL flush: got %h expected %h", obs, expv()); errs++;
    end
    for (int i = 0; i < 5; i++) push(8'($urandom));
    #2 rst = 1;
    #1;
    q.delete(); ovr = 0;
    vecs++;
    if (obs !== 19'd0) begin
      $display("FAIL async_rst: got %h expected %h", obs, 19'd0); errs++;
    end
    @(negedge clk);
    cyc();
    rst = 0;
    cyc();
    vecs++;
    if (obs !== expv()) begin
      $display("FAIL post_rst: got %h expected %h", obs, expv()); errs++;
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int i = 0; i < 400; i++) begin
      rx_valid = $urandom_range(0, 99) < 55;
      rx_data = 8'($urandom);
      rx_fe = $urandom_range(0, 9) == 0;
      rx_pe = $urandom_range(0, 9) == 0;
      m_ready = $urandom_range(0, 99) < (i < 200 ? 35 : 65);
      flush = $urandom_range(0, 99) < 3;
      overrun_clr = $urandom_range(0, 99) < 5;
      cyc();
      vecs++;
      if (obs !== expv()) begin
        $display("FAIL random_%0d: got %h expected %h", i, obs, expv()); errs++;
      end
    end
    rx_valid = 0; rx_fe = 0; rx_pe = 0; m_ready = 0; flush = 0; overrun_clr = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_fill_overrun();
    test_full_pop();
    test_drop_err();
    test_timeout();
    test_flush_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
